// File: rtl/min_max_dist_if.sv
// Memory/handshake bundle for min_max_dist_engine: start/done acknowledge plus a
// single-port byte memory (asynchronous read, write on clk edge).
interface min_max_dist_if;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;

  modport master (
    input  start,
    input  mem_rdata,
    output done,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport slave (
    output start,
    output mem_rdata,
    input  done,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );
endinterface

// File: rtl/min_max_dist_engine.sv
// Loads 32 signed 16-bit values from bytes 0..63, finds min/max |v[j]-v[k]| over all pairs,
// writes results to bytes 66..69. Optional macro PAIR_INDEX_EN adds winning pair indices at 70..73.
module min_max_dist_engine (
  input  logic           clk,
  input  logic           rst_n,
  min_max_dist_if.master bus
);

  localparam int DATA_W = 16;
  localparam int IDX_W  = 5;
`ifdef PAIR_INDEX_EN
  localparam logic [2:0] WR_LAST = 3'd7;
`else
  localparam logic [2:0] WR_LAST = 3'd3;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_WRITE, S_DONE} state_t;

  state_t                   state;
  state_t                   next_state;
  logic                     armed;
  logic                     done_r;
  logic [5:0]               ld_cnt;
  logic [IDX_W-1:0]         j_idx;
  logic [IDX_W-1:0]         k_idx;
  logic [2:0]               wr_cnt;
  logic [DATA_W-1:0]        min_dist;
  logic [DATA_W-1:0]        max_dist;
  logic [7:0]               hi_byte;
  logic signed [DATA_W-1:0] vals [32];
  logic signed [DATA_W:0]   diff_p0;
  logic [DATA_W-1:0]        dist_p0;
  logic [7:0]               wr_byte;
  logic                     load_last;
  logic                     scan_last;
  logic                     wr_last;
`ifdef PAIR_INDEX_EN
  logic [IDX_W-1:0]         min_j;
  logic [IDX_W-1:0]         min_k;
  logic [IDX_W-1:0]         max_j;
  logic [IDX_W-1:0]         max_k;
`endif

  // Magnitude of the 17-bit difference; the largest possible value (65535) still fits in 16 bits.
  function automatic logic [DATA_W-1:0] abs_trunc(input logic signed [DATA_W:0] d);
    logic signed [DATA_W:0] mag;
    mag = d[DATA_W] ? -d : d;
    return mag[DATA_W-1:0];
  endfunction

  assign load_last = (ld_cnt == 6'd63);
  assign scan_last = (j_idx == 5'd30) && (k_idx == 5'd31);
  assign wr_last   = (wr_cnt == WR_LAST);

  // Stage p0: distance of the current (j, k) pair, consumed on the same edge
  always_comb begin
    diff_p0 = $signed({vals[j_idx][DATA_W-1], vals[j_idx]})
            - $signed({vals[k_idx][DATA_W-1], vals[k_idx]});
    dist_p0 = abs_trunc(diff_p0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.start) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (armed)     next_state = S_LOAD;
        S_LOAD:  if (load_last) next_state = S_SCAN;
        S_SCAN:  if (scan_last) next_state = S_WRITE;
        S_WRITE: if (wr_last)   next_state = S_DONE;
        S_DONE:                 next_state = S_DONE;
        default:                next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_byte = 8'h00;
    case (wr_cnt)
      3'd0:    wr_byte = min_dist[15:8];
      3'd1:    wr_byte = min_dist[7:0];
      3'd2:    wr_byte = max_dist[15:8];
      3'd3:    wr_byte = max_dist[7:0];
`ifdef PAIR_INDEX_EN
      3'd4:    wr_byte = {3'b000, min_k};
      3'd5:    wr_byte = {3'b000, min_j};
      3'd6:    wr_byte = {3'b000, max_k};
      3'd7:    wr_byte = {3'b000, max_j};
`endif
      default: wr_byte = 8'h00;
    endcase
  end

  // A start sampled high kills the write combinationally so an abort never lands a byte.
  always_comb begin
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = 8'h00;
    bus.mem_we    = 1'b0;
    bus.done      = done_r;
    case (state)
      S_LOAD:  bus.mem_addr = {2'b00, ld_cnt};
      S_WRITE: begin
        bus.mem_addr  = 8'd66 + {5'd0, wr_cnt};
        bus.mem_wdata = wr_byte;
        bus.mem_we    = !bus.start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      done_r   <= 1'b0;
      ld_cnt   <= '0;
      j_idx    <= '0;
      k_idx    <= '0;
      wr_cnt   <= '0;
      min_dist <= 16'hFFFF;
      max_dist <= 16'h0000;
`ifdef PAIR_INDEX_EN
      min_j    <= '0;
      min_k    <= '0;
      max_j    <= '0;
      max_k    <= '0;
`endif
    end else begin
      if (bus.start)                                armed <= 1'b1;
      else if (state == S_IDLE && armed)            armed <= 1'b0;
      done_r <= (state == S_DONE) && !bus.start;
      case (state)
        S_IDLE: begin
          ld_cnt   <= '0;
          j_idx    <= '0;
          k_idx    <= 5'd1;
          wr_cnt   <= '0;
          min_dist <= 16'hFFFF;
          max_dist <= 16'h0000;
`ifdef PAIR_INDEX_EN
          min_j    <= '0;
          min_k    <= '0;
          max_j    <= '0;
          max_k    <= '0;
`endif
        end
        S_LOAD: ld_cnt <= ld_cnt + 6'd1;
        S_SCAN: begin
          // Strict compares keep the earliest pair on ties
          if (dist_p0 < min_dist) begin
            min_dist <= dist_p0;
`ifdef PAIR_INDEX_EN
            min_j    <= j_idx;
            min_k    <= k_idx;
`endif
          end
          if (dist_p0 > max_dist) begin
            max_dist <= dist_p0;
`ifdef PAIR_INDEX_EN
            max_j    <= j_idx;
            max_k    <= k_idx;
`endif
          end
          if (k_idx == 5'd31) begin
            j_idx <= j_idx + 5'd1;
            k_idx <= j_idx + 5'd2;
          end else begin
            k_idx <= k_idx + 5'd1;
          end
        end
        S_WRITE: wr_cnt <= wr_cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Stage p0 capture: even bytes are the high half, odd bytes complete a value
  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      if (!ld_cnt[0]) hi_byte <= bus.mem_rdata;
      else            vals[ld_cnt[5:1]] <= {hi_byte, bus.mem_rdata};
    end
  end

endmodule

// File: doc/min_max_dist_engine.md
MIN_MAX_DIST_ENGINE -- requirements
Module: min_max_dist_engine

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request from the initiator; high = hold/abort, falling to low = run.
REQ-004 SHALL have port: done  output  1  acknowledge; level, registered.
REQ-005 SHALL have port: mem_addr  output  8  byte address into the 256x8 data memory.
REQ-006 SHALL have port: mem_rdata  input  8  read data; valid in the same cycle as mem_addr (asynchronous read).
REQ-007 SHALL have port: mem_wdata  output  8  write data.
REQ-008 SHALL have port: mem_we  output  1  write enable; the memory writes on the clk edge.

Function
REQ-009 SHALL implement states IDLE, LOAD, SCAN, WRITE and DONE.
REQ-010 SHALL hold an internal armed flag, set whenever start is sampled high; rst_n clears it.
REQ-011 SHALL move from IDLE to LOAD on an edge that samples start=0 with armed=1, and SHALL clear armed on that edge.
REQ-012 SHALL, on sampling start=1 in any state, go to IDLE on that edge with done=0, mem_we=0, and no further memory writes.
REQ-013 LOAD SHALL read bytes 0..63 over 64 cycles and form value i as signed {byte[2i], byte[2i+1]}, i=0..31 (big-endian).
REQ-014 SCAN SHALL evaluate one pair per cycle for 496 cycles: j outer 0..30, k inner j+1..31.
REQ-015 Distance SHALL be computed as diff = 17-bit signed (v[j] - v[k]); dist = -diff if diff[16] else diff; result truncated to 16 bits (range 0..65535).
REQ-016 Min SHALL start at 0xFFFF and update only when dist < Min (strict).
REQ-017 Max SHALL start at 0x0000 and update only when dist > Max (strict).
REQ-018 Ties SHALL keep the earlier pair in scan order.
REQ-019 WRITE SHALL issue one byte per cycle: addr 66 = Min[15:8], 67 = Min[7:0], 68 = Max[15:8], 69 = Max[7:0], with mem_we=1 in each of those cycles only.
REQ-020 SHALL never write any address other than 66..69 (plus 70..73 when PAIR_INDEX_EN is defined).
REQ-021 DONE SHALL hold done=1 until start is sampled high.
REQ-022 Latency: counting edge E0 as the edge that samples start low, done SHALL be high after edge E0+565 (64 LOAD + 496 SCAN + 4 WRITE + 1), with no idle cycles inserted.
REQ-023 mem_we SHALL be 0 in IDLE, LOAD, SCAN and DONE.

Reset
REQ-024 Asserting rst_n low SHALL immediately force: state=IDLE, done=0, mem_we=0, mem_addr=0, mem_wdata=0, armed=0, Min=0xFFFF, Max=0x0000, all counters 0.
REQ-025 After reset is released, a run SHALL begin only after start has been sampled high and then sampled low.
REQ-026 Reset asserted mid-operation SHALL abort the run with no partial writes completing after assertion.

Configuration
REQ-027 With macro PAIR_INDEX_EN defined: SHALL track the winning pair indices and, after byte 69, write 70 = Min k, 71 = Min j, 72 = Max k, 73 = Max j (5-bit indices zero-extended); done latency becomes E0+569.
REQ-028 With PAIR_INDEX_EN undefined: SHALL contain no index registers, SHALL write only 66..69, and latency SHALL be as in REQ-022.

Verification
REQ-029 All 32 values = 0x0005; start 1->0 -> Core[66..69] = 00,00,00,00; done rises exactly 565 edges after E0.
REQ-030 Value i = 3*i -> Min = 0x0003, Max = 0x005D; Core[66..69] = 00,03,00,5D.
REQ-031 v0 = 0x8000, v1 = 0x7FFF, rest 0 -> Max = 0xFFFF, Min = 0x0000 (17-bit abs boundary).
REQ-032 Core[66..69] preset to 0xFF; start raised at SCAN cycle 300 -> IDLE next edge, done=0, Core[66..69] still 0xFF; start lowered again -> full correct run.
REQ-033 rst_n pulsed low during LOAD -> all outputs 0 immediately; start held low afterwards -> no run; start 1->0 -> normal run.
REQ-034 PAIR_INDEX_EN defined, value i = 3*i -> Core[70..73] = 1,0,31,0; done at E0+569.
